// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a framed byte stream, assembles
// big-endian words, writes them out and gates CPU reset on a good checksum.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, HDR, DATA, WRITE, CSUM, DONE, ERR
  } state_t;

  localparam logic [7:0] MAXN = 8'(MAX_WORDS);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  n_q;
  logic [7:0]  widx;
  logic [7:0]  csum;
  logic [1:0]  bidx;
  logic [23:0] word;
  logic        xfer;

  assign xfer = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and Moore output decode
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    cpu_hold  = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = HDR;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_nxt = HDR;
      end
      ERR: begin
        err = 1'b1;
        if (start) state_nxt = HDR;
      end
      HDR: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) begin
          if (in_data == 8'd0 || in_data > MAXN) state_nxt = ERR;
          else                                    state_nxt = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && bidx == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
        if (widx == n_q - 8'd1) state_nxt = CSUM;
        else                    state_nxt = DATA;
      end
      CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) begin
          if (in_data == csum) state_nxt = DONE;
          else                 state_nxt = ERR;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: counters, byte assembly, checksum and held write port
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q       <= '0;
      widx      <= '0;
      csum      <= '0;
      bidx      <= '0;
      word      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            widx <= '0;
            csum <= '0;
            bidx <= '0;
          end
        end
        HDR: begin
          if (xfer) begin
            n_q  <= in_data;
            bidx <= '0;
          end
        end
        DATA: begin
          if (xfer) begin
            word <= {word[15:0], in_data};
            csum <= csum ^ in_data;
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              mem_wdata <= {word, in_data};
              mem_addr  <= ADDR_W'({widx, 2'b00});
            end
          end
        end
        WRITE: begin
          widx <= widx + 8'd1;
          bidx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
